// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Runs one fully-connected layer through the single-MAC accelerator. For every
// neuron it streams VEC_LEN weights then VEC_LEN image words from memory into the
// accelerator buffer, waits for the MAC to drain, reads the result and stores it.
// CPU programs base addresses and neuron count through a small CSR slave.
//
// Optional build macro: NN_SEQ_RELU_EN
//   defined   -> negative results (bit31 set) are stored as 0, NaN passes unchanged
//   undefined -> results are stored exactly as read from the accelerator
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; done/busy reflect the last run
// FETCH      | mem_read held with address until waitrequest drops
// FETCH_WAIT | single outstanding read, waiting for readdatavalid
// PUSH       | one-cycle acc_write of the fetched word, then index update
// DRAIN      | fixed wait for the accelerator to finish accumulating
// RES_RD     | one-cycle acc_read of the result register
// RES_CAP    | capture acc_readdata, launch the result write
// STORE      | mem_write held until waitrequest drops, next neuron or done

module nn_layer_sequencer #(
    parameter int VEC_LEN      = 96,
    parameter int DRAIN_CYCLES = 4,
    parameter int NEURON_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        irq,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    output logic [7:0]  acc_address,
    output logic        acc_write,
    output logic        acc_read,
    output logic [31:0] acc_writedata,
    input  logic [31:0] acc_readdata
);

    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_LEN - 1);
    localparam logic [DRN_W-1:0] DRAIN_LD  = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [7:0]       ACC_W0    = 8'h01;
    localparam logic [7:0]       ACC_I0    = 8'h61;
    localparam logic [7:0]       ACC_RES   = 8'hC1;

    typedef enum logic [2:0] {
        IDLE, FETCH, FETCH_WAIT, PUSH, DRAIN, RES_RD, RES_CAP, STORE
    } state_t;

    state_t              state;
    logic [31:0]         weight_base;
    logic [31:0]         image_base;
    logic [31:0]         result_base;
    logic [NEURON_W-1:0] num_neurons;
    logic [NEURON_W-1:0] n;
    logic [IDX_W-1:0]    i;
    logic                phase_img;
    logic [31:0]         w_ptr;
    logic [31:0]         img_ptr;
    logic [31:0]         res_ptr;
    logic [DRN_W-1:0]    drain_cnt;
    logic                busy;
    logic                done;

    logic ctrl_wr;
    logic start_req;
    logic clr_req;

    assign ctrl_wr   = csr_write && (csr_address == 3'd0);
    assign start_req = ctrl_wr && csr_writedata[0];
    assign clr_req   = ctrl_wr && csr_writedata[1];
    assign irq       = done;

    // Result post-processing; NaN is left alone so software can still detect it.
    function automatic logic [31:0] post_proc(input logic [31:0] v);
`ifdef NN_SEQ_RELU_EN
        if (v[31] && !((v[30:23] == 8'hFF) && (v[22:0] != 23'd0)))
            return 32'h0;
        return v;
`else
        return v;
`endif
    endfunction

    // Configuration registers and the layer sequencing FSM with registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            weight_base   <= '0;
            image_base    <= '0;
            result_base   <= '0;
            num_neurons   <= '0;
            n             <= '0;
            i             <= '0;
            phase_img     <= 1'b0;
            w_ptr         <= '0;
            img_ptr       <= '0;
            res_ptr       <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            acc_address   <= '0;
            acc_write     <= 1'b0;
            acc_read      <= 1'b0;
            acc_writedata <= '0;
        end else begin
            if (csr_write && !busy) begin
                case (csr_address)
                    3'd2:    weight_base <= csr_writedata;
                    3'd3:    image_base  <= csr_writedata;
                    3'd4:    result_base <= csr_writedata;
                    3'd5:    num_neurons <= csr_writedata[NEURON_W-1:0];
                    default: ;
                endcase
            end

            // start overrides this below when both bits are written together
            if (clr_req)
                done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_req) begin
                        if (num_neurons == '0) begin
                            done <= 1'b1;
                        end else begin
                            done        <= 1'b0;
                            busy        <= 1'b1;
                            n           <= '0;
                            i           <= '0;
                            phase_img   <= 1'b0;
                            w_ptr       <= weight_base;
                            res_ptr     <= result_base;
                            mem_address <= weight_base;
                            mem_read    <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= FETCH_WAIT;
                    end
                end

                FETCH_WAIT: begin
                    if (mem_readdatavalid) begin
                        acc_write     <= 1'b1;
                        acc_writedata <= mem_readdata;
                        acc_address   <= (phase_img ? ACC_I0 : ACC_W0) + 8'(i);
                        state         <= PUSH;
                    end
                end

                PUSH: begin
                    acc_write <= 1'b0;
                    if (i != LAST_IDX) begin
                        i        <= i + IDX_W'(1);
                        mem_read <= 1'b1;
                        state    <= FETCH;
                        if (phase_img) begin
                            img_ptr     <= img_ptr + 32'd4;
                            mem_address <= img_ptr + 32'd4;
                        end else begin
                            w_ptr       <= w_ptr + 32'd4;
                            mem_address <= w_ptr + 32'd4;
                        end
                    end else if (!phase_img) begin
                        // w_ptr now points at the next neuron's first weight
                        phase_img   <= 1'b1;
                        i           <= '0;
                        w_ptr       <= w_ptr + 32'd4;
                        img_ptr     <= image_base;
                        mem_address <= image_base;
                        mem_read    <= 1'b1;
                        state       <= FETCH;
                    end else begin
                        drain_cnt <= DRAIN_LD;
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == '0) begin
                        acc_read    <= 1'b1;
                        acc_address <= ACC_RES;
                        state       <= RES_RD;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end

                RES_RD: begin
                    acc_read <= 1'b0;
                    state    <= RES_CAP;
                end

                RES_CAP: begin
                    mem_writedata <= post_proc(acc_readdata);
                    mem_address   <= res_ptr;
                    mem_write     <= 1'b1;
                    state         <= STORE;
                end

                STORE: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        if (n != num_neurons - NEURON_W'(1)) begin
                            n           <= n + NEURON_W'(1);
                            res_ptr     <= res_ptr + 32'd4;
                            phase_img   <= 1'b0;
                            i           <= '0;
                            mem_address <= w_ptr;
                            mem_read    <= 1'b1;
                            state       <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // CSR read-back with one cycle of latency; CTRL and unmapped addresses read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                3'd1:    csr_readdata <= {16'(n), 14'd0, done, busy};
                3'd2:    csr_readdata <= weight_base;
                3'd3:    csr_readdata <= image_base;
                3'd4:    csr_readdata <= result_base;
                3'd5:    csr_readdata <= 32'(num_neurons);
                default: csr_readdata <= '0;
            endcase
        end else begin
            csr_readdata <= '0;
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Testbench for nn_layer_sequencer: memory slave with programmable waitrequest and
// read latency, a behavioural accelerator, and a queue-based reference of the
// expected fetch / push / store sequences for each layer run.
module tb_nn_layer_sequencer;
    localparam int VL = 96;

    logic        clk;
    logic        reset;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [7:0]  acc_address;
    logic        acc_write;
    logic        acc_read;
    logic [31:0] acc_writedata;
    logic [31:0] acc_readdata;

    nn_layer_sequencer dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .acc_address(acc_address), .acc_write(acc_write), .acc_read(acc_read),
        .acc_writedata(acc_writedata), .acc_readdata(acc_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [7:0] a; logic [31:0] d; } acc_ev_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } mem_ev_t;
    typedef struct { bit wr; logic [2:0] a; logic [31:0] d; logic [31:0] exp; } csr_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int prot_viol = 0;
    int strobe_cnt = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] abuf [256];
    acc_ev_t     acc_log[$];
    mem_ev_t     wr_log[$];
    logic [31:0] rd_log[$];

    int          wait_cfg;      // <0: random 0..3 wait cycles per request
    int          rd_dly_max;
    bit          ovr_en;
    logic [31:0] ovr_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    // Behavioural accelerator: a position-sensitive multiply-accumulate over the buffer.
    function automatic logic [31:0] acc_term(input logic [31:0] w, input logic [31:0] x, input int k);
        return w * x + w + (x ^ 32'(k));
    endfunction

    function automatic logic [31:0] relu_ref(input logic [31:0] v);
`ifdef NN_SEQ_RELU_EN
        bit is_nan;
        is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return (v[31] && !is_nan) ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Memory slave: stalls each new request, logs accepted traffic, returns read data later.
    initial begin
        bit          in_req, stalled, rd_pend, req_wr;
        int          left, dly;
        logic [31:0] req_a, req_d, rd_a;
        in_req = 0; stalled = 0; rd_pend = 0; req_wr = 0; left = 0; dly = 0;
        req_a = 0; req_d = 0; rd_a = 0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_readdatavalid = 1'b0;
            if (reset) begin
                in_req = 0; stalled = 0; rd_pend = 0; mem_waitrequest = 1'b0;
                continue;
            end
            if (rd_pend) begin
                if (dly == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = mrd(rd_a);
                    rd_pend = 0;
                end else begin
                    dly--;
                end
            end
            if (mem_read || mem_write) begin
                if (!in_req) begin
                    in_req = 1; req_a = mem_address; req_wr = mem_write; req_d = mem_writedata;
                    left = (wait_cfg < 0) ? int'($urandom_range(3, 0)) : wait_cfg;
                end else if (mem_address !== req_a || mem_write !== req_wr ||
                             (req_wr && mem_writedata !== req_d)) begin
                    prot_viol++;
                    $display("FAIL mem_hold: address %h changed to %h under waitrequest", req_a, mem_address);
                end
                if (left > 0) begin
                    mem_waitrequest = 1'b1; left--; stalled = 1;
                end else begin
                    mem_waitrequest = 1'b0; in_req = 0; stalled = 0;
                    if (mem_read) begin
                        rd_pend = 1; rd_a = mem_address;
                        dly = int'($urandom_range(rd_dly_max, 0));
                        rd_log.push_back(mem_address);
                    end else begin
                        mem[mem_address] = mem_writedata;
                        wr_log.push_back('{mem_address, mem_writedata});
                    end
                end
            end else begin
                if (stalled) begin
                    prot_viol++;
                    $display("FAIL mem_hold: request dropped while waitrequest high, got 0 expected 1");
                end
                in_req = 0; stalled = 0; mem_waitrequest = 1'b0;
            end
        end
    end

    // Accelerator model plus strobe protocol monitor.
    initial begin
        bit          pend_rd, prev_w, prev_r;
        logic [31:0] s;
        pend_rd = 0; prev_w = 0; prev_r = 0;
        acc_readdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                pend_rd = 0; prev_w = 0; prev_r = 0;
                continue;
            end
            if (pend_rd) begin
                s = 0;
                for (int k = 0; k < VL; k++) s += acc_term(abuf[1 + k], abuf[97 + k], k);
                acc_readdata = ovr_en ? ovr_val : s;
                pend_rd = 0;
            end
            if (int'(mem_read) + int'(mem_write) + int'(acc_write) + int'(acc_read) > 1) begin
                prot_viol++;
                $display("FAIL strobe_excl: strobes %b%b%b%b expected one-hot", mem_read, mem_write, acc_write, acc_read);
            end
            if (mem_read || mem_write || acc_write || acc_read) strobe_cnt++;
            if (acc_write) begin
                if (prev_w) begin
                    prot_viol++;
                    $display("FAIL acc_write_pulse: got 2 cycles expected 1");
                end
                abuf[acc_address] = acc_writedata;
                acc_log.push_back('{acc_address, acc_writedata});
            end
            if (acc_read) begin
                if (prev_r || acc_address !== 8'hC1) begin
                    prot_viol++;
                    $display("FAIL acc_read: addr %h repeat %0d expected addr c1 single pulse", acc_address, prev_r);
                end
                pend_rd = 1;
            end
            prev_w = acc_write;
            prev_r = acc_read;
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic fill(input logic [31:0] wb, input logic [31:0] ib, input int nn, input bit rnd);
        for (int n = 0; n < nn; n++)
            for (int k = 0; k < VL; k++)
                mem[wb + 32'(4 * (n * VL + k))] = rnd ? $urandom : 32'h3F80_0000;
        for (int k = 0; k < VL; k++)
            mem[ib + 32'(4 * k)] = rnd ? $urandom : 32'h4000_0000;
    endtask

    // Builds the expected traffic from memory contents, runs the layer, compares.
    task automatic run_layer(input string tag, input logic [31:0] wb, input logic [31:0] ib,
                             input logic [31:0] rb, input int nn, input bit poke);
        acc_ev_t     exp_acc[$];
        mem_ev_t     exp_wr[$];
        logic [31:0] exp_rd[$];
        logic [31:0] sum, wa, ia, st;
        bit          seen_last;
        int          cyc, budget, wm;

        for (int n = 0; n < nn; n++) begin
            sum = 0;
            for (int k = 0; k < VL; k++) begin
                wa = wb + 32'(4 * (n * VL + k));
                exp_rd.push_back(wa);
                exp_acc.push_back('{8'(1 + k), mrd(wa)});
            end
            for (int k = 0; k < VL; k++) begin
                wa = wb + 32'(4 * (n * VL + k));
                ia = ib + 32'(4 * k);
                exp_rd.push_back(ia);
                exp_acc.push_back('{8'(97 + k), mrd(ia)});
                sum += acc_term(mrd(wa), mrd(ia), k);
            end
            exp_wr.push_back('{rb + 32'(4 * n), relu_ref(ovr_en ? ovr_val : sum)});
        end

        acc_log.delete(); wr_log.delete(); rd_log.delete();
        csr_wr(3'd2, wb); csr_wr(3'd3, ib); csr_wr(3'd4, rb); csr_wr(3'd5, 32'(nn));
        csr_wr(3'd0, 32'h1);

        wm = (wait_cfg < 0) ? 3 : wait_cfg;
        budget = nn * (2 * VL * (wm + rd_dly_max + 6) + wm + 40) + 200;
        seen_last = 0;
        cyc = 0;
        while (irq !== 1'b1 && cyc < budget) begin
            if (!seen_last && rd_log.size() > (nn - 1) * 2 * VL) begin
                seen_last = 1;
                csr_rd(3'd1, st);
                check($sformatf("%s status_last_neuron", tag), st, {16'(nn - 1), 16'h0001});
                if (poke) begin
                    csr_wr(3'd2, 32'hFFFF_0000);
                    csr_wr(3'd0, 32'h1);
                    csr_rd(3'd2, st);
                    check($sformatf("%s busy_cfg_ignored", tag), st, wb);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("%s finished_in_budget", tag), 32'(irq === 1'b1), 32'd1);
        csr_rd(3'd1, st);
        check($sformatf("%s status_done", tag), {30'd0, st[1:0]}, 32'h2);

        check($sformatf("%s fetch_count", tag), 32'(rd_log.size()), 32'(exp_rd.size()));
        for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++) begin
            check($sformatf("%s fetch_addr[%0d]", tag, k), rd_log[k], exp_rd[k]);
            if (rd_log[k] !== exp_rd[k]) break;
        end
        check($sformatf("%s push_count", tag), 32'(acc_log.size()), 32'(exp_acc.size()));
        for (int k = 0; k < exp_acc.size() && k < acc_log.size(); k++) begin
            check($sformatf("%s push[%0d]", tag, k), {acc_log[k].a, acc_log[k].d[23:0]},
                  {exp_acc[k].a, exp_acc[k].d[23:0]});
            check($sformatf("%s push_hi[%0d]", tag, k), 32'(acc_log[k].d[31:24]), 32'(exp_acc[k].d[31:24]));
            if (acc_log[k] != exp_acc[k]) break;
        end
        check($sformatf("%s store_count", tag), 32'(wr_log.size()), 32'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++) begin
            check($sformatf("%s store_addr[%0d]", tag, k), wr_log[k].a, exp_wr[k].a);
            check($sformatf("%s store_data[%0d]", tag, k), wr_log[k].d, exp_wr[k].d);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s strobes", tag), {27'd0, mem_read, mem_write, acc_write, acc_read, irq}, 32'd0);
        check($sformatf("%s mem_address", tag), mem_address, 32'd0);
        check($sformatf("%s mem_writedata", tag), mem_writedata, 32'd0);
        check($sformatf("%s acc_address", tag), 32'(acc_address), 32'd0);
        check($sformatf("%s acc_writedata", tag), acc_writedata, 32'd0);
        check($sformatf("%s csr_readdata", tag), csr_readdata, 32'd0);
    endtask

    initial begin
        csr_vec_t    tbl[14];
        logic [31:0] v, res1, exp6;
        int          cyc, snap;

        reset = 1'b1; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
        wait_cfg = 0; rd_dly_max = 0; ovr_en = 0; ovr_val = '0;

        tbl[0]  = '{0, 3'd1, 32'h0,          32'h0};
        tbl[1]  = '{1, 3'd2, 32'h1122_3344,  32'h0};
        tbl[2]  = '{1, 3'd3, 32'h5566_7788,  32'h0};
        tbl[3]  = '{1, 3'd4, 32'h9ABC_DEF0,  32'h0};
        tbl[4]  = '{1, 3'd5, 32'hABCD_0003,  32'h0};
        tbl[5]  = '{0, 3'd2, 32'h0,          32'h1122_3344};
        tbl[6]  = '{0, 3'd3, 32'h0,          32'h5566_7788};
        tbl[7]  = '{0, 3'd4, 32'h0,          32'h9ABC_DEF0};
        tbl[8]  = '{0, 3'd5, 32'h0,          32'h0000_0003};
        tbl[9]  = '{0, 3'd0, 32'h0,          32'h0};
        tbl[10] = '{0, 3'd6, 32'h0,          32'h0};
        tbl[11] = '{0, 3'd7, 32'h0,          32'h0};
        tbl[12] = '{1, 3'd0, 32'h0000_0002,  32'h0};
        tbl[13] = '{0, 3'd1, 32'h0,          32'h0};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            if (tbl[k].wr) csr_wr(tbl[k].a, tbl[k].d);
            else begin
                csr_rd(tbl[k].a, v);
                check($sformatf("csr_tbl[%0d]", k), v, tbl[k].exp);
            end
        end

        // Zero neurons: done almost immediately, no traffic at all.
        csr_wr(3'd5, 32'h0);
        snap = strobe_cnt;
        csr_wr(3'd0, 32'h1);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 2) begin @(posedge clk); #1; cyc++; end
        check("zero_neuron_irq", 32'(irq), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("zero_neuron_no_strobes", 32'(strobe_cnt - snap), 32'd0);
        csr_rd(3'd1, v);
        check("zero_neuron_status", v, 32'h2);
        csr_wr(3'd0, 32'h2);
        check("clear_done_irq", 32'(irq), 32'd0);
        csr_wr(3'd0, 32'h3);
        check("start_beats_clear", 32'(irq), 32'd1);
        csr_wr(3'd0, 32'h2);

        // Single neuron, 1.0 weights and 2.0 image, zero-wait memory.
        fill(32'h0000_0100, 32'h0000_2000, 1, 0);
        run_layer("t1", 32'h0000_0100, 32'h0000_2000, 32'h0000_3000, 1, 0);
        res1 = (wr_log.size() > 0) ? wr_log[0].d : 32'hxxxx_xxxx;
        check("t1_irq", 32'(irq), 32'd1);

        // Three neurons with busy-time writes poked in during the last neuron.
        fill(32'h0000_1000, 32'h0000_4000, 3, 1);
        run_layer("t2", 32'h0000_1000, 32'h0000_4000, 32'h0000_5000, 3, 1);
        check("t2_neuron2_first_weight", (rd_log.size() > 384) ? rd_log[384] : 32'hxxxx_xxxx, 32'h0000_1300);

        // Same data as t1 behind a slow, stalling memory.
        wait_cfg = 5; rd_dly_max = 3;
        fill(32'h0000_0100, 32'h0000_2000, 1, 0);
        run_layer("t3", 32'h0000_0100, 32'h0000_2000, 32'h0000_3000, 1, 0);
        check("t3_same_as_t1", (wr_log.size() > 0) ? wr_log[0].d : 32'hxxxx_xxxx, res1);

        // Reset in the middle of the image phase, then a clean re-run.
        wait_cfg = 1; rd_dly_max = 1;
        acc_log.delete();
        csr_wr(3'd2, 32'h0000_0100); csr_wr(3'd3, 32'h0000_2000);
        csr_wr(3'd4, 32'h0000_3000); csr_wr(3'd5, 32'h1);
        csr_wr(3'd0, 32'h1);
        cyc = 0;
        while (acc_log.size() < VL + 40 && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        check("t5_reached_i40", 32'(acc_log.size() >= VL + 40), 32'd1);
        reset = 1'b1;
        #1;
        check_outputs_zero("t5_async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        csr_rd(3'd1, v);
        check("t5_status_after_reset", v, 32'h0);
        csr_rd(3'd2, v);
        check("t5_cfg_after_reset", v, 32'h0);
        run_layer("t5_rerun", 32'h0000_0100, 32'h0000_2000, 32'h0000_3000, 1, 0);

        // Negative and NaN results through the optional ReLU.
        wait_cfg = 0; rd_dly_max = 0;
        ovr_en = 1; ovr_val = 32'hC060_0000;
`ifdef NN_SEQ_RELU_EN
        exp6 = 32'h0000_0000;
`else
        exp6 = 32'hC060_0000;
`endif
        run_layer("t6_neg", 32'h0000_0100, 32'h0000_2000, 32'h0000_3000, 1, 0);
        check("t6_neg_stored", (wr_log.size() > 0) ? wr_log[0].d : 32'hxxxx_xxxx, exp6);
        ovr_val = 32'hFFC0_0000;
        run_layer("t6_nan", 32'h0000_0100, 32'h0000_2000, 32'h0000_3000, 1, 0);
        check("t6_nan_stored", (wr_log.size() > 0) ? wr_log[0].d : 32'hxxxx_xxxx, 32'hFFC0_0000);
        ovr_en = 0;

        // Weight region wrapping past 2^32.
        wait_cfg = -1; rd_dly_max = 2;
        fill(32'hFFFF_FF00, 32'h0000_6000, 2, 1);
        run_layer("wrap", 32'hFFFF_FF00, 32'h0000_6000, 32'h0000_7000, 2, 0);

        // Randomized layers.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] wb, ib, rb;
            int          nn;
            wb = 32'h0010_0000 + (32'($urandom_range(15, 0)) << 12);
            ib = 32'h0020_0000 + (32'($urandom_range(15, 0)) << 12);
            rb = 32'h0030_0000 + (32'($urandom_range(15, 0)) << 12);
            nn = int'($urandom_range(3, 1));
            wait_cfg = -1;
            rd_dly_max = int'($urandom_range(3, 0));
            fill(wb, ib, nn, 1);
            run_layer($sformatf("rnd%0d", r), wb, ib, rb, nn, r[0]);
        end

        check("protocol_violations", 32'(prot_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
